// File: rtl/i2c_reg_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// i2c_reg_access_ctrl_pkg
//   Shared definitions for the I2C register access controller and its
//   neighbours (slave front end, register file): default data/address widths
//   and the 2-bit encoding of the access-sequencing FSM states.
// ---------------------------------------------------------------------------
package i2c_reg_access_ctrl_pkg;

  // Default data width of register file words and I2C bytes.
  localparam int unsigned WORD_SIZE_DEF = 32'd8;

  // Default register address width; the pointer wraps modulo 2**ADDR_W.
  localparam int unsigned ADDR_W_DEF = 32'd8;

  // Access-sequencing FSM, fixed 2-bit encoding shared with the front end.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // no transfer addressed to us
    ST_PTR   = 2'b01,  // write transfer, waiting for the pointer byte
    ST_WDATA = 2'b10,  // write transfer, data bytes go to the register file
    ST_RDATA = 2'b11   // read transfer, bytes come from the register file
  } state_e;

endpackage

// File: rtl/i2c_addr_ptr.sv
// ---------------------------------------------------------------------------
// i2c_addr_ptr
//   Register pointer for the I2C register access controller. Loads a new
//   value or increments (wrapping modulo 2**ADDR_W, no carry flag).
//   Load has priority over increment; the controller never requests both.
// Ports:
//   clk       in   system clock (posedge)
//   reset     in   asynchronous active-low reset, pointer clears to 0
//   load      in   load ptr from load_val this cycle
//   load_val  in   ADDR_W value to load
//   inc       in   increment ptr this cycle
//   ptr       out  ADDR_W current pointer (registered)
// ---------------------------------------------------------------------------
module i2c_addr_ptr #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;

  // Next pointer value: load, increment with natural wrap, or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= {ADDR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/i2c_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_reg_access_ctrl
//   Sequences host accesses from the I2C slave byte front end into an 8-bit
//   register file. In a write transfer the first byte loads the register
//   pointer and every later byte is written at the pointer, which then
//   increments. In a read transfer bytes are returned from the pointer with
//   auto-increment. The pointer survives START/STOP, so a pointer write
//   followed by a repeated START read reads from the loaded address.
//
// Optional feature (macro I2C_REGCTRL_WPROT_EN):
//   Addresses >= PROT_BASE are write-protected; blocked bytes raise a
//   1-cycle wp_hit pulse instead of rf_en, and the pointer still increments.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   start_det  in   START / repeated START pulse
//   stop_det   in   STOP pulse
//   addr_match in   own slave address ACKed pulse, qualifies rw
//   rw         in   1 = read transfer
//   rx_valid   in   received byte pulse, rx_data valid
//   rx_data    in   received byte
//   tx_req     in   front end requests next read byte
//   tx_valid   out  tx_data valid pulse (1 cycle after tx_req)
//   tx_data    out  byte to transmit
//   rf_sr      out  register file read address (= ptr, combinational)
//   rf_dr      out  register file write address
//   rf_wdata   out  register file write data
//   rf_en      out  register file write enable pulse (1 cycle after rx_valid)
//   rf_rdata   in   register file read data, combinational from rf_sr
//   busy       out  transfer in progress (state != IDLE)
//   ptr        out  current register pointer
//   wp_hit     out  blocked-write pulse (only with I2C_REGCTRL_WPROT_EN)
// ---------------------------------------------------------------------------
module i2c_reg_access_ctrl
  import i2c_reg_access_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned          ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]    PROT_BASE = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_det,
  input  logic                 stop_det,
  input  logic                 addr_match,
  input  logic                 rw,
  input  logic                 rx_valid,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 tx_req,
  output logic                 tx_valid,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic [ADDR_W-1:0]    rf_sr,
  output logic [ADDR_W-1:0]    rf_dr,
  output logic [WORD_SIZE-1:0] rf_wdata,
  output logic                 rf_en,
  input  logic [WORD_SIZE-1:0] rf_rdata,
  output logic                 busy,
  output logic [ADDR_W-1:0]    ptr
`ifdef I2C_REGCTRL_WPROT_EN
  ,
  output logic                 wp_hit
`endif
);

  state_e               state_d,    state_q;
  logic                 tx_valid_d, tx_valid_q;
  logic [WORD_SIZE-1:0] tx_data_d,  tx_data_q;
  logic                 rf_en_d,    rf_en_q;
  logic [ADDR_W-1:0]    rf_dr_d,    rf_dr_q;
  logic [WORD_SIZE-1:0] rf_wdata_d, rf_wdata_q;
  logic                 busy_d,     busy_q;
`ifdef I2C_REGCTRL_WPROT_EN
  logic                 wp_hit_d,   wp_hit_q;
`endif

  logic                 ptr_load_s;
  logic                 ptr_inc_s;
  logic [ADDR_W-1:0]    ptr_s;
  logic                 wr_allow_s;

  i2c_addr_ptr #(
    .ADDR_W (ADDR_W)
  ) u_addr_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load_s),
    .load_val (rx_data[ADDR_W-1:0]),
    .inc      (ptr_inc_s),
    .ptr      (ptr_s)
  );

  // Write permission for the byte at the current pointer.
  always_comb begin
`ifdef I2C_REGCTRL_WPROT_EN
    wr_allow_s = (ptr_s < PROT_BASE);
`else
    wr_allow_s = 1'b1;
`endif
  end

  // Next-state and output logic. START beats STOP beats data; the only data
  // that survives a simultaneous STOP is a WDATA byte, which is still written.
  always_comb begin
    state_d    = state_q;
    ptr_load_s = 1'b0;
    ptr_inc_s  = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    rf_en_d    = 1'b0;
    rf_dr_d    = rf_dr_q;
    rf_wdata_d = rf_wdata_q;
`ifdef I2C_REGCTRL_WPROT_EN
    wp_hit_d   = 1'b0;
`endif

    if (start_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (addr_match) begin
            state_d = rw ? ST_RDATA : ST_PTR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PTR: begin
          if (rx_valid && !stop_det) begin
            ptr_load_s = 1'b1;
            state_d    = ST_WDATA;
          end else begin
            state_d    = ST_PTR;
          end
        end
        ST_WDATA: begin
          if (rx_valid) begin
            ptr_inc_s = 1'b1;
            if (wr_allow_s) begin
              rf_en_d    = 1'b1;
              rf_dr_d    = ptr_s;
              rf_wdata_d = rx_data;
            end else begin
`ifdef I2C_REGCTRL_WPROT_EN
              wp_hit_d   = 1'b1;
`endif
            end
          end else begin
            ptr_inc_s = 1'b0;
          end
        end
        ST_RDATA: begin
          if (tx_req && !stop_det) begin
            tx_valid_d = 1'b1;
            tx_data_d  = rf_rdata;
            ptr_inc_s  = 1'b1;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (stop_det) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_d;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset also cancels any pending pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= {WORD_SIZE{1'b0}};
      rf_en_q    <= 1'b0;
      rf_dr_q    <= {ADDR_W{1'b0}};
      rf_wdata_q <= {WORD_SIZE{1'b0}};
      busy_q     <= 1'b0;
`ifdef I2C_REGCTRL_WPROT_EN
      wp_hit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rf_en_q    <= rf_en_d;
      rf_dr_q    <= rf_dr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
`ifdef I2C_REGCTRL_WPROT_EN
      wp_hit_q   <= wp_hit_d;
`endif
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rf_sr    = ptr_s;
  assign rf_dr    = rf_dr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_en    = rf_en_q;
  assign busy     = busy_q;
  assign ptr      = ptr_s;
`ifdef I2C_REGCTRL_WPROT_EN
  assign wp_hit   = wp_hit_q;
`endif

endmodule
